// File: rtl/isa_pkg.sv
// Shared ISA definitions for the program loader: mnemonic codes, the fixed
// opcode map, loader FSM states and the 32-bit instruction field layout.
package isa_pkg;

  typedef enum logic [3:0] {
    MN_RTYPE = 4'd0,
    MN_ADDI  = 4'd1,
    MN_SUBI  = 4'd2,
    MN_ANDI  = 4'd3,
    MN_ORI   = 4'd4,
    MN_SLTI  = 4'd5,
    MN_LW    = 4'd6,
    MN_LB    = 4'd7,
    MN_SW    = 4'd8,
    MN_SB    = 4'd9,
    MN_BEQ   = 4'd10,
    MN_BNE   = 4'd11,
    MN_MOVE  = 4'd12,
    MN_J     = 4'd13,
    MN_JAL   = 4'd14
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SUBI  = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_SB    = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_MOVE  = 6'b100000;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  localparam int OP_LSB     = 26;
  localparam int OP_W       = 6;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int REG_W      = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 6;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;
  localparam int TARGET_LSB = 0;
  localparam int TARGET_W   = 26;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

  function automatic logic [5:0] opcode_of(input mnem_e m);
    case (m)
      MN_ADDI: return OP_ADDI;
      MN_SUBI: return OP_SUBI;
      MN_ANDI: return OP_ANDI;
      MN_ORI:  return OP_ORI;
      MN_SLTI: return OP_SLTI;
      MN_LW:   return OP_LW;
      MN_LB:   return OP_LB;
      MN_SW:   return OP_SW;
      MN_SB:   return OP_SB;
      MN_BEQ:  return OP_BEQ;
      MN_BNE:  return OP_BNE;
      MN_MOVE: return OP_MOVE;
      MN_J:    return OP_J;
      MN_JAL:  return OP_JAL;
      default: return OP_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// Instruction request channel: mnemonic plus operand fields over valid/ready.
interface instr_encode_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  mnem;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output in_valid, in_last, mnem, rs, rt, rd, funct, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, mnem, rs, rt, rd, funct, imm, target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Combinational encoder: mnemonic and operand fields to a 32-bit instruction
// word, flagging codes outside the mnemonic set as illegal.
module instr_encoder
  import isa_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    word  = '0;
    legal = 1'b1;
    case (mnem)
      MN_RTYPE: begin
        word[OP_LSB +: OP_W]       = OP_RTYPE;
        word[RS_LSB +: REG_W]      = rs;
        word[RT_LSB +: REG_W]      = rt;
        word[RD_LSB +: REG_W]      = rd;
        word[FUNCT_LSB +: FUNCT_W] = funct;
      end
      MN_ADDI, MN_SUBI, MN_ANDI, MN_ORI, MN_SLTI, MN_LW, MN_LB,
      MN_SW, MN_SB, MN_BEQ, MN_BNE: begin
        word[OP_LSB +: OP_W]   = opcode_of(mnem_e'(mnem));
        word[RS_LSB +: REG_W]  = rs;
        word[RT_LSB +: REG_W]  = rt;
        word[IMM_LSB +: IMM_W] = imm;
      end
      MN_MOVE: begin
        word[OP_LSB +: OP_W]  = OP_MOVE;
        word[RS_LSB +: REG_W] = rs;
        word[RT_LSB +: REG_W] = rt;
      end
      MN_J, MN_JAL: begin
        word[OP_LSB +: OP_W]         = opcode_of(mnem_e'(mnem));
        word[TARGET_LSB +: TARGET_W] = target;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts instruction requests, encodes them and writes the
// words sequentially into instruction memory through a registered write port.
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned BASE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encode_loader_if.slave  req,
  output logic                  imem_we,
  output logic [AW-1:0]         imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  err_illegal,
  output logic [AW:0]           word_count
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  state_e        state;
  logic [AW-1:0] ptr;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          accept;
  logic          write_fire;
  logic          last_word;
  logic [AW:0]   count_inc;

  instr_encoder u_encoder (
    .mnem   (req.mnem),
    .rs     (req.rs),
    .rt     (req.rt),
    .rd     (req.rd),
    .funct  (req.funct),
    .imm    (req.imm),
    .target (req.target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  assign req.in_ready = (state == ST_LOAD) && !full;
  assign accept       = req.in_valid && req.in_ready;
  assign write_fire   = accept && enc_legal;
  assign count_inc    = word_count + (AW+1)'(1);
  assign last_word    = write_fire && (count_inc == DEPTH_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= BASE_ADDR;
      imem_we     <= 1'b0;
      imem_addr   <= BASE_ADDR;
      imem_wdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      word_count  <= '0;
    end else begin
      // The write port sees every accepted legal word, even one that
      // coincides with a restart.
      imem_we <= write_fire;
      if (write_fire) begin
        imem_addr  <= ptr;
        imem_wdata <= enc_word;
      end

      if (start) begin
        state       <= ST_LOAD;
        ptr         <= BASE_ADDR;
        busy        <= 1'b1;
        done        <= 1'b0;
        full        <= 1'b0;
        err_illegal <= 1'b0;
        word_count  <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (accept) begin
              if (write_fire) begin
                word_count <= count_inc;
                full       <= last_word;
                if (!last_word) ptr <= ptr + AW'(1);
              end else begin
                err_illegal <= 1'b1;
              end
              if (req.in_last || last_word) begin
                state <= ST_DONE;
                done  <= 1'b1;
                // Busy stays up through the cycle that carries the final write.
                busy  <= write_fire;
              end
            end
          end
          default: busy <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed scenarios plus
// randomized sessions against an opcode-table reference model.
module tb_instr_encode_loader;
  import isa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic start_a, start_b, v_a, v_b, f_last;
  logic [3:0]  f_mnem;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic [5:0]  f_funct;
  logic [15:0] f_imm;
  logic [25:0] f_target;

  instr_encode_loader_if ifa ();
  instr_encode_loader_if ifb ();

  assign ifa.in_valid = v_a;      assign ifb.in_valid = v_b;
  assign ifa.in_last  = f_last;   assign ifb.in_last  = f_last;
  assign ifa.mnem     = f_mnem;   assign ifb.mnem     = f_mnem;
  assign ifa.rs       = f_rs;     assign ifb.rs       = f_rs;
  assign ifa.rt       = f_rt;     assign ifb.rt       = f_rt;
  assign ifa.rd       = f_rd;     assign ifb.rd       = f_rd;
  assign ifa.funct    = f_funct;  assign ifb.funct    = f_funct;
  assign ifa.imm      = f_imm;    assign ifb.imm      = f_imm;
  assign ifa.target   = f_target; assign ifb.target   = f_target;

  logic        we_a, busy_a, done_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  wc_a;
  logic        we_b, busy_b, done_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  wc_b;

  instr_encode_loader #(.DEPTH(256), .AW(8), .BASE(0)) dut (
    .clk(clk), .reset(reset), .start(start_a), .req(ifa.slave),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .full(full_a), .err_illegal(err_a),
    .word_count(wc_a)
  );

  instr_encode_loader #(.DEPTH(4), .AW(2), .BASE(0)) dut4 (
    .clk(clk), .reset(reset), .start(start_b), .req(ifb.slave),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .full(full_b), .err_illegal(err_b),
    .word_count(wc_b)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t log_a[$];
  wr_t log_b[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we_a === 1'b1) log_a.push_back('{addr: int'(addr_a), data: wdata_a, cyc: cyc});
    if (we_b === 1'b1) log_b.push_back('{addr: int'(addr_b), data: wdata_b, cyc: cyc});
  end

  // Reference encoder built from the opcode map as plain shifted fields.
  function automatic bit model_encode(input int m, input logic [4:0] rs, rt, rd,
                                      input logic [5:0] funct, input logic [15:0] imm,
                                      input logic [25:0] tgt, output logic [31:0] w);
    int op_tab[15] = '{'h00, 'h02, 'h03, 'h04, 'h05, 'h07, 'h08, 'h09,
                       'h10, 'h11, 'h23, 'h27, 'h20, 'h38, 'h39};
    logic [31:0] op;
    w = 32'h0;
    if (m < 0 || m > 14) return 1'b0;
    op = 32'(op_tab[m]) << 26;
    if (m == 0)
      w = op | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(funct);
    else if (m == 12)
      w = op | (32'(rs) << 21) | (32'(rt) << 16);
    else if (m >= 13)
      w = op | 32'(tgt);
    else
      w = op | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return 1'b1;
  endfunction

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic idle();
    v_a = 1'b0;
    v_b = 1'b0;
    f_last = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until a handshake edge or the budget runs out.
  task automatic send(input bit sel, input logic [3:0] m, input logic [4:0] rs, rt, rd,
                      input logic [5:0] funct, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit last, input int budget, output bit acc);
    bit rdy;
    f_mnem = m; f_rs = rs; f_rt = rt; f_rd = rd;
    f_funct = funct; f_imm = imm; f_target = tgt; f_last = last;
    if (sel) v_b = 1'b1; else v_a = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < budget && !acc; k++) begin
      @(negedge clk);
      rdy = sel ? ifb.in_ready : ifa.in_ready;
      @(posedge clk); #1;
      if (rdy) acc = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({ifa.in_ready, we_a, busy_a, done_a, full_a, err_a} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000",
                        {ifa.in_ready, we_a, busy_a, done_a, full_a, err_a});
    end
    n_cmp++;
    if ({addr_a, wdata_a, wc_a} !== 49'h0) begin
      n_bad++; $display("FAIL reset_values: got addr=%h wdata=%h count=%0d want 0/0/0",
                        addr_a, wdata_a, wc_a);
    end
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_single_addi();
    bit acc;
    log_a.delete();
    pulse_start(0);
    send(0, MN_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1, 4, acc);
    idle();
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", acc); end
    n_cmp++;
    if ({we_a, addr_a, wdata_a} !== {1'b1, 8'h00, 32'h08220005}) begin
      n_bad++; $display("FAIL single_write: got we=%b addr=%h wdata=%h want 1/00/08220005",
                        we_a, addr_a, wdata_a);
    end
    n_cmp++;
    if ({done_a, busy_a, wc_a} !== {1'b1, 1'b1, 9'd1}) begin
      n_bad++; $display("FAIL single_status: got done=%b busy=%b count=%0d want 1/1/1",
                        done_a, busy_a, wc_a);
    end
    wait_cycles(1);
    n_cmp++;
    if ({we_a, busy_a, ifa.in_ready, done_a} !== 4'b0001) begin
      n_bad++; $display("FAIL single_after: got we/busy/ready/done=%b want 0001",
                        {we_a, busy_a, ifa.in_ready, done_a});
    end
  endtask

  task automatic test_back_to_back();
    bit acc0, acc1, acc2;
    logic [31:0] exp_d[3] = '{32'h00642820, 32'h8C22FFFE, 32'hE4000010};
    log_a.delete();
    pulse_start(0);
    send(0, MN_RTYPE, 5'd3, 5'd4, 5'd5, 6'h20, 16'h0, 26'h0, 1'b0, 4, acc0);
    send(0, MN_BEQ, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFE, 26'h0, 1'b0, 1, acc1);
    send(0, MN_JAL, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1'b1, 1, acc2);
    idle();
    wait_cycles(2);
    n_cmp++;
    if ({acc0, acc1, acc2} !== 3'b111 || log_a.size() != 3) begin
      n_bad++; $display("FAIL b2b_count: got acc=%b writes=%0d want 111/3",
                        {acc0, acc1, acc2}, log_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (log_a[i].addr != i || log_a[i].data !== exp_d[i] || log_a[i].cyc != log_a[0].cyc + i) begin
          n_bad++; $display("FAIL b2b_word%0d: got addr=%0d data=%h cyc+%0d want %0d/%h/+%0d",
                            i, log_a[i].addr, log_a[i].data, log_a[i].cyc - log_a[0].cyc,
                            i, exp_d[i], i);
        end
      end
    end
  endtask

  task automatic test_illegal();
    bit acc0, acc1, acc2;
    logic [31:0] e0, e1;
    void'(model_encode(6, 5'd7, 5'd8, 5'd0, 6'd0, 16'h0040, 26'd0, e0));
    void'(model_encode(6, 5'd9, 5'd10, 5'd0, 6'd0, 16'h1234, 26'd0, e1));
    log_a.delete();
    pulse_start(0);
    send(0, MN_LW, 5'd7, 5'd8, 5'd0, 6'd0, 16'h0040, 26'd0, 1'b0, 4, acc0);
    send(0, 4'd15, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 26'd1, 1'b0, 1, acc1);
    send(0, MN_LW, 5'd9, 5'd10, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1, 1, acc2);
    idle();
    wait_cycles(2);
    n_cmp++;
    if ({acc0, acc1, acc2, err_a, done_a, wc_a} !== {5'b11111, 9'd2}) begin
      n_bad++; $display("FAIL illegal_status: got acc=%b err=%b done=%b count=%0d want 111/1/1/2",
                        {acc0, acc1, acc2}, err_a, done_a, wc_a);
    end
    n_cmp++;
    if (log_a.size() != 2) begin
      n_bad++; $display("FAIL illegal_writes: got %0d want 2", log_a.size());
    end else begin
      n_cmp++;
      if (log_a[0].addr != 0 || log_a[1].addr != 1 || log_a[0].data !== e0 || log_a[1].data !== e1) begin
        n_bad++; $display("FAIL illegal_words: got %0d:%h %0d:%h want 0:%h 1:%h",
                          log_a[0].addr, log_a[0].data, log_a[1].addr, log_a[1].data, e0, e1);
      end
    end
  endtask

  task automatic test_full();
    bit acc;
    int n_acc = 0;
    log_b.delete();
    pulse_start(1);
    for (int i = 0; i < 6; i++) begin
      send(1, MN_ADDI, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(i), 26'd0, 1'b0, 3, acc);
      if (acc) begin
        n_acc++;
        if (n_acc == 4) begin
          n_cmp++;
          if ({we_b, full_b, ifb.in_ready, busy_b, wc_b} !== {4'b1101, 3'd4}) begin
            n_bad++; $display("FAIL full_edge: got we/full/ready/busy=%b count=%0d want 1101/4",
                              {we_b, full_b, ifb.in_ready, busy_b}, wc_b);
          end
        end
      end
    end
    idle();
    wait_cycles(1);
    n_cmp++;
    if (n_acc != 4 || log_b.size() != 4) begin
      n_bad++; $display("FAIL full_accepts: got accepted=%0d writes=%0d want 4/4", n_acc, log_b.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_b[i].addr != i) begin
          n_bad++; $display("FAIL full_addr%0d: got %0d want %0d", i, log_b[i].addr, i);
        end
      end
    end
    n_cmp++;
    if ({full_b, done_b, busy_b, ifb.in_ready} !== 4'b1100) begin
      n_bad++; $display("FAIL full_done: got full/done/busy/ready=%b want 1100",
                        {full_b, done_b, busy_b, ifb.in_ready});
    end
  endtask

  task automatic test_reset_mid();
    bit acc0, acc1, acc2;
    log_a.delete();
    pulse_start(0);
    send(0, MN_SW, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 4, acc0);
    send(0, MN_SB, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0020, 26'd0, 1'b0, 1, acc1);
    idle();
    wait_cycles(1);
    f_mnem = MN_ORI; v_a = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ifa.in_ready, we_a, busy_a, done_a, full_a, err_a, addr_a, wdata_a, wc_a} !== 55'h0) begin
      n_bad++; $display("FAIL midreset_values: got ready=%b we=%b busy=%b addr=%h wdata=%h count=%0d want all 0",
                        ifa.in_ready, we_a, busy_a, addr_a, wdata_a, wc_a);
    end
    wait_cycles(3);
    n_cmp++;
    if ({acc0, acc1} !== 2'b11 || log_a.size() != 2) begin
      n_bad++; $display("FAIL midreset_writes: got acc=%b writes=%0d want 11/2", {acc0, acc1}, log_a.size());
    end
    idle();
    reset = 1'b0;
    wait_cycles(1);
    pulse_start(0);
    send(0, MN_ANDI, 5'd5, 5'd6, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b1, 4, acc2);
    idle();
    n_cmp++;
    if ({acc2, we_a, addr_a, wc_a} !== {2'b11, 8'h00, 9'd1}) begin
      n_bad++; $display("FAIL midreset_restart: got acc=%b we=%b addr=%h count=%0d want 1/1/00/1",
                        acc2, we_a, addr_a, wc_a);
    end
    wait_cycles(1);
  endtask

  task automatic test_restart();
    bit acc;
    pulse_start(0);
    send(0, MN_SUBI, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0, 4, acc);
    send(0, 4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b0, 4, acc);
    send(0, MN_SLTI, 5'd2, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0, 4, acc);
    send(0, MN_LB, 5'd3, 5'd3, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b0, 4, acc);
    idle();
    wait_cycles(1);
    n_cmp++;
    if ({wc_a, err_a} !== {9'd3, 1'b1}) begin
      n_bad++; $display("FAIL restart_pre: got count=%0d err=%b want 3/1", wc_a, err_a);
    end
    pulse_start(0);
    n_cmp++;
    if ({wc_a, err_a, done_a, busy_a, ifa.in_ready} !== {9'd0, 4'b0011}) begin
      n_bad++; $display("FAIL restart_clear: got count=%0d err/done/busy/ready=%b want 0/0011",
                        wc_a, {err_a, done_a, busy_a, ifa.in_ready});
    end
    send(0, MN_MOVE, 5'd4, 5'd5, 5'd0, 6'd0, 16'hBEEF, 26'd0, 1'b1, 4, acc);
    idle();
    n_cmp++;
    if ({we_a, addr_a, wdata_a, wc_a} !== {1'b1, 8'h00, 32'h80850000, 9'd1}) begin
      n_bad++; $display("FAIL restart_write: got we=%b addr=%h wdata=%h count=%0d want 1/00/80850000/1",
                        we_a, addr_a, wdata_a, wc_a);
    end
    wait_cycles(1);
  endtask

  task automatic test_start_with_valid();
    log_a.delete();
    f_mnem = MN_J; f_target = 26'h2ABCDEF; f_last = 1'b1;
    v_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n_cmp++;
    if ({we_a, wc_a, ifa.in_ready} !== {1'b0, 9'd0, 1'b1}) begin
      n_bad++; $display("FAIL startvalid_edge: got we=%b count=%0d ready=%b want 0/0/1",
                        we_a, wc_a, ifa.in_ready);
    end
    @(posedge clk); #1;
    idle();
    n_cmp++;
    if ({we_a, addr_a, wdata_a, wc_a} !== {1'b1, 8'h00, 32'hE2ABCDEF, 9'd1}) begin
      n_bad++; $display("FAIL startvalid_next: got we=%b addr=%h wdata=%h count=%0d want 1/00/e2abcdef/1",
                        we_a, addr_a, wdata_a, wc_a);
    end
    wait_cycles(1);
  endtask

  task automatic test_random_sessions();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    bit exp_err, acc, leg, last;
    int n_req, m;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic [15:0] im;
    logic [25:0] tg;
    for (int s = 0; s < 4; s++) begin
      log_a.delete();
      exp_q.delete();
      exp_err = 1'b0;
      n_req = $urandom_range(10, 30);
      pulse_start(0);
      for (int i = 0; i < n_req; i++) begin
        m  = $urandom_range(0, 15);
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        fn = 6'($urandom); im = 16'($urandom); tg = 26'($urandom);
        last = (i == n_req - 1);
        leg = model_encode(m, rs, rt, rd, fn, im, tg, w);
        if (leg) exp_q.push_back(w); else exp_err = 1'b1;
        send(0, 4'(m), rs, rt, rd, fn, im, tg, last, 4, acc);
        n_cmp++;
        if (acc !== 1'b1) begin
          n_bad++; $display("FAIL rand_accept s%0d r%0d: got %b want 1", s, i, acc);
        end
        if ($urandom_range(0, 3) == 0 && !last) begin
          idle();
          wait_cycles($urandom_range(1, 3));
        end
      end
      idle();
      wait_cycles(2);
      n_cmp++;
      if ({err_a, done_a, busy_a} !== {exp_err, 2'b10} || wc_a != 9'(exp_q.size())) begin
        n_bad++; $display("FAIL rand_status s%0d: got err=%b done=%b busy=%b count=%0d want %b/1/0/%0d",
                          s, err_a, done_a, busy_a, wc_a, exp_err, exp_q.size());
      end
      n_cmp++;
      if (log_a.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rand_writes s%0d: got %0d want %0d", s, log_a.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++;
          if (log_a[i].addr != i || log_a[i].data !== exp_q[i]) begin
            n_bad++; $display("FAIL rand_word s%0d w%0d: got %0d:%h want %0d:%h",
                              s, i, log_a[i].addr, log_a[i].data, i, exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start_a = 1'b0; start_b = 1'b0;
    v_a = 1'b0; v_b = 1'b0; f_last = 1'b0;
    f_mnem = '0; f_rs = '0; f_rt = '0; f_rd = '0;
    f_funct = '0; f_imm = '0; f_target = '0;
    test_reset();
    test_single_addi();
    test_back_to_back();
    test_illegal();
    test_full();
    test_reset_mid();
    test_restart();
    test_start_with_valid();
    test_random_sessions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Program-load block: the encoder counterpart of the datapath's opcode decoder. It accepts instruction requests (mnemonic plus fields) over a valid/ready handshake and encodes each into a 32-bit instruction word using the team's fixed opcode map. It writes the words sequentially into instruction memory through a registered write port. It sits between the testbench/boot source and instruction memory, ahead of processor release from reset.

Parameters:
DEPTH, 256, instruction memory depth in words; must be a power of 2.
AW, 8, address width; equals log2(DEPTH).
BASE, 0, first word address written after start.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse: begin a load session at BASE.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request this cycle.
in_last  in  1  marks the final request of the session.
mnem  in  4  instruction mnemonic code, enumerated in package.
rs, rt, rd  in  5 each  register fields.
funct  in  6  R-type function field.
imm  in  16  I-type immediate.
target  in  26  J-type target.
imem_we  out  1  instruction memory write strobe.
imem_addr  out  AW  write address.
imem_wdata  out  32  encoded instruction.
busy  out  1  session active.
done  out  1  session complete; sticky until next start or reset.
full  out  1  DEPTH words written.
err_illegal  out  1  sticky: illegal mnemonic seen this session.
word_count  out  AW+1  words written this session.

Behaviour:
- Reset (async, immediate): state=IDLE. in_ready, imem_we, busy, done, full and err_illegal are 0. imem_addr=BASE. imem_wdata=0. word_count=0.
- FSM states are IDLE, LOAD and DONE.
  - IDLE --start--> LOAD. This clears done, full, err_illegal and word_count, and sets the write pointer to BASE.
  - LOAD --(accepted in_last) or (full)--> DONE.
  - DONE --start--> LOAD.
  - A start pulse while in LOAD restarts the session exactly as from IDLE; any in-flight write still completes.
- in_ready = (state==LOAD) && !full. A handshake fires when in_valid && in_ready.
- Encoding for each accepted request:
  - R-type: {000000, rs, rt, rd, 5'b0, funct}.
  - I-type: {op, rs, rt, imm}. This covers ADDI 000010, SUBI 000011, ANDI 000100, ORI 000101, SLTI 000111, LW 001000, LB 001001, SW 010000, SB 010001, BEQ 100011 and BNE 100111.
  - MOVE 100000: {op, rs, rt, 16'b0}; the imm input is ignored.
  - J 111000 and JAL 111001: {op, target}.
- Latency: a request accepted at cycle N produces imem_we=1 at cycle N+1, with the registered addr and wdata. imem_we is a 1-cycle pulse per word. Back-to-back acceptance sustains 1 word per cycle.
- After each write, the pointer increments and word_count increments.
- When word_count reaches DEPTH, full=1 in the same cycle as the last write. in_ready then drops, the state goes to DONE, and the pointer does not wrap.
- Illegal mnemonic (any code outside the enum):
  - The request is accepted (handshake completes) and err_illegal is set.
  - No write is issued; pointer and count are unchanged.
  - If in_last accompanies it, the session still ends.
- in_last accepted together with a legal instruction: that word is written, then done=1 in the write cycle.
- Outputs in DONE and IDLE: busy=0. busy=1 in LOAD, including the cycle of the final write.
- Reset asserted mid-session aborts immediately. A partially loaded memory is left as written; no write occurs after reset rises.
- start together with in_valid in the same cycle: the request is not accepted, because in_ready is evaluated from the pre-start state.

Decomposition:
- Shared package (isa_pkg) holds:
  - the mnemonic enum, 4-bit, codes 0..14;
  - the 6-bit opcode constants above;
  - the R-type opcode;
  - the instruction field bit positions.
- Sub-module instr_encoder: purely combinational (mnem, fields) -> (word, legal).
- The top holds the FSM, pointer/counter and output registers.

Test Plan:
- Reset, start, then ADDI rs=1 rt=2 imm=0x0005 with in_last -> one write at addr 0: wdata 0x08220005, done=1, word_count=1.
- Stream R-type (rs=3, rt=4, rd=5, funct=0x20), then BEQ (rs=1, rt=2, imm=0xFFFE), then JAL (target=0x0000010), back-to-back -> writes at 0, 1, 2 on consecutive cycles: 0x00642820, 0x8C22FFFE, 0xE4000010.
- Illegal mnem=15 between two LW requests -> err_illegal=1; LWs land at addr 0 and 1 with no gap in addresses; word_count=2.
- DEPTH=4: send 6 requests without in_last -> 4 writes, full=1, in_ready=0 after the 4th, state DONE; the remaining requests are never accepted.
- Assert reset mid-stream after 2 writes -> all outputs return to reset values next edge-independent instant. A new start then writes again from addr 0.
- start pulse while in LOAD after 3 words -> word_count returns to 0 and the next write goes to BASE.
